// File: rtl/unified_mem_arbiter_if.sv
// Request/response bundle between the IF/MEM stages, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-ported unified memory arbiter: fetch vs. load/store, one fixed-latency
// transaction at a time, registered ready/rdata, fetch abort on flush.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic             clk,
  input logic             reset,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              abort_q, abort_d;
  logic              own_d_q, own_d_d;
  logic              we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              arb_en, req_d, req_i, grant_d, grant_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    abort_d     = abort_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    // DONE arbitrates like IDLE; the requester being served this cycle still
    // holds its req, so mask it unless its transaction was aborted.
    arb_en  = (state_q == IDLE) || (state_q == DONE);
    req_d   = bus.d_req & ~((state_q == DONE) & own_d_q);
    req_i   = bus.if_req & ~bus.if_flush & ~((state_q == DONE) & ~own_d_q & ~abort_q);
    grant_d = arb_en & req_d & ~(req_i & last_d_q);
    grant_i = arb_en & req_i & ~grant_d;

    case (state_q)
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (own_d_q) begin
            d_ready_d = 1'b1;
            if (!we_q) d_rdata_d = bus.mem_rdata;
          end else if (!(abort_q | bus.if_flush)) begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if ((state_q != IDLE) && !own_d_q && bus.if_flush) abort_d = 1'b1;
    if (state_q == DONE) abort_d = 1'b0;

    if (grant_d | grant_i) begin
      state_d    = ISSUE;
      own_d_d    = grant_d;
      we_d       = grant_d & bus.d_we;
      last_d_d   = grant_d;
      abort_d    = 1'b0;
      mem_en_d   = 1'b1;
      mem_we_d   = grant_d & bus.d_we;
      mem_addr_d = grant_d ? bus.d_addr : bus.if_addr;
      if (grant_d) mem_wdata_d = bus.d_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      abort_q     <= 1'b0;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      abort_q     <= abort_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req & ~bus.if_ready & ~bus.if_flush;
  assign bus.stall_mem = bus.d_req & ~bus.d_ready;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: cycle-numbered scenarios with
// hand-computed expectations against a fixed-latency memory model.
module tb_unified_mem_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int nvec = 0, nerr = 0;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h2002FFFF;
      32'h44:  return 32'h44444444;
      32'h80:  return 32'h80808080;
      32'h100: return 32'h11110100;
      default: return 32'hA5000000 | a;
    endcase
  endfunction

  // Memory: read data appears LAT cycles after the mem_en cycle, garbage otherwise.
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? lookup(bus.mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[LAT-1];

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (2) next_cycle();
    nvec++; if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready} !== 4'b0) begin nerr++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready}); end
    nvec++; if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 128'h0) begin nerr++;
      $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata}); end
    @(negedge clk); reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin bus.if_req = 1; bus.if_addr = 32'h40; end
      if (c == 5) bus.if_req = 0;
      @(negedge clk);
      nvec++; if (bus.mem_en !== (c == 1)) begin nerr++;
        $display("FAIL fetch_mem_en c%0d: got %b expected %b", c, bus.mem_en, c == 1); end
      if (c == 1) begin
        nvec++; if (bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin nerr++;
          $display("FAIL fetch_mem_addr: got %h we %b expected 00000040 we 0", bus.mem_addr, bus.mem_we); end
      end
      nvec++; if (bus.if_ready !== (c == 4)) begin nerr++;
        $display("FAIL fetch_if_ready c%0d: got %b expected %b", c, bus.if_ready, c == 4); end
      if (c == 4) begin
        nvec++; if (bus.if_rdata !== 32'h2002FFFF) begin nerr++;
          $display("FAIL fetch_if_rdata: got %h expected 2002ffff", bus.if_rdata); end
      end
      nvec++; if (bus.stall_if !== (c <= 3)) begin nerr++;
        $display("FAIL fetch_stall_if c%0d: got %b expected %b", c, bus.stall_if, c <= 3); end
    end
  endtask

  task automatic test_priority();
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c == 0) begin
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
      end
      if (c == 5) bus.d_req = 0;
      if (c == 9) bus.if_req = 0;
      @(negedge clk);
      nvec++; if (bus.mem_en !== (c == 1 || c == 5)) begin nerr++;
        $display("FAIL prio_mem_en c%0d: got %b expected %b", c, bus.mem_en, c == 1 || c == 5); end
      if (c == 1 || c == 5) begin
        nvec++; if (bus.mem_addr !== (c == 1 ? 32'h100 : 32'h40)) begin nerr++;
          $display("FAIL prio_mem_addr c%0d: got %h expected %h", c, bus.mem_addr, c == 1 ? 32'h100 : 32'h40); end
      end
      nvec++; if (bus.d_ready !== (c == 4) || bus.if_ready !== (c == 8)) begin nerr++;
        $display("FAIL prio_ready c%0d: got d %b i %b expected d %b i %b", c, bus.d_ready, bus.if_ready, c == 4, c == 8); end
      if (c == 4) begin
        nvec++; if (bus.d_rdata !== 32'h11110100) begin nerr++;
          $display("FAIL prio_d_rdata: got %h expected 11110100", bus.d_rdata); end
      end
      if (c == 8) begin
        nvec++; if (bus.if_rdata !== 32'h2002FFFF) begin nerr++;
          $display("FAIL prio_if_rdata: got %h expected 2002ffff", bus.if_rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      if (c == 0) begin
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
      end
      if (c == 13) bus.d_req = 0;
      if (c == 17) bus.if_req = 0;
      @(negedge clk);
      nvec++; if (bus.mem_en !== (c == 1 || c == 5 || c == 9 || c == 13)) begin nerr++;
        $display("FAIL b2b_mem_en c%0d: got %b", c, bus.mem_en); end
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        nvec++; if (bus.mem_addr !== ((c == 1 || c == 9) ? 32'h100 : 32'h40)) begin nerr++;
          $display("FAIL b2b_grant_order c%0d: got %h expected %h", c, bus.mem_addr, (c == 1 || c == 9) ? 32'h100 : 32'h40); end
      end
      nvec++; if (bus.d_ready !== (c == 4 || c == 12) || bus.if_ready !== (c == 8 || c == 16)) begin nerr++;
        $display("FAIL b2b_ready c%0d: got d %b i %b", c, bus.d_ready, bus.if_ready); end
      nvec++; if (bus.d_ready && bus.if_ready) begin nerr++;
        $display("FAIL b2b_overlap c%0d: got both ready expected at most one", c); end
    end
  endtask

  task automatic test_store();
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      if (c == 0) begin bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'hDEADBEEF; end
      if (c == 5) begin bus.d_req = 0; bus.d_we = 0; end
      @(negedge clk);
      nvec++; if (bus.mem_en !== (c == 1) || bus.mem_we !== (c == 1)) begin nerr++;
        $display("FAIL store_strobe c%0d: got en %b we %b expected %b", c, bus.mem_en, bus.mem_we, c == 1); end
      if (c == 1) begin
        nvec++; if (bus.mem_addr !== 32'h200 || bus.mem_wdata !== 32'hDEADBEEF) begin nerr++;
          $display("FAIL store_bus: got %h/%h expected 00000200/deadbeef", bus.mem_addr, bus.mem_wdata); end
      end
      nvec++; if (bus.d_ready !== (c == 4)) begin nerr++;
        $display("FAIL store_d_ready c%0d: got %b expected %b", c, bus.d_ready, c == 4); end
      nvec++; if (bus.stall_mem !== (c <= 3)) begin nerr++;
        $display("FAIL store_stall_mem c%0d: got %b expected %b", c, bus.stall_mem, c <= 3); end
      nvec++; if (bus.d_rdata !== 32'h11110100) begin nerr++;
        $display("FAIL store_d_rdata c%0d: got %h expected 11110100", c, bus.d_rdata); end
    end
  endtask

  // Last grant was D, so a simultaneous request must go to fetch first.
  task automatic test_fairness();
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      if (c == 0) begin
        bus.if_req = 1; bus.if_addr = 32'h40;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100;
      end
      if (c == 5) bus.if_req = 0;
      if (c == 9) bus.d_req = 0;
      @(negedge clk);
      if (c == 1 || c == 5) begin
        nvec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== (c == 1 ? 32'h40 : 32'h100)) begin nerr++;
          $display("FAIL fair_grant c%0d: got en %b addr %h expected 1 %h", c, bus.mem_en, bus.mem_addr, c == 1 ? 32'h40 : 32'h100); end
      end
      nvec++; if (bus.if_ready !== (c == 4) || bus.d_ready !== (c == 8)) begin nerr++;
        $display("FAIL fair_ready c%0d: got i %b d %b", c, bus.if_ready, bus.d_ready); end
    end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c == 0) begin bus.if_req = 1; bus.if_addr = 32'h44; end
      if (c == 2) begin bus.if_flush = 1; bus.if_req = 0; end
      if (c == 3) begin bus.if_flush = 0; bus.if_req = 1; bus.if_addr = 32'h80; end
      if (c == 9) bus.if_req = 0;
      @(negedge clk);
      nvec++; if (bus.mem_en !== (c == 1 || c == 5)) begin nerr++;
        $display("FAIL flush_mem_en c%0d: got %b", c, bus.mem_en); end
      if (c == 5) begin
        nvec++; if (bus.mem_addr !== 32'h80) begin nerr++;
          $display("FAIL flush_refetch_addr: got %h expected 00000080", bus.mem_addr); end
      end
      nvec++; if (bus.if_ready !== (c == 8)) begin nerr++;
        $display("FAIL flush_if_ready c%0d: got %b expected %b", c, bus.if_ready, c == 8); end
      if (c >= 4 && c <= 7) begin
        nvec++; if (bus.if_rdata !== 32'h2002FFFF) begin nerr++;
          $display("FAIL flush_if_rdata_kept c%0d: got %h expected 2002ffff", c, bus.if_rdata); end
      end
      if (c == 8) begin
        nvec++; if (bus.if_rdata !== 32'h80808080) begin nerr++;
          $display("FAIL flush_refetch_data: got %h expected 80808080", bus.if_rdata); end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 16; c++) begin
      next_cycle();
      if (c == 0) begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; end
      if (c == 2) begin
        reset = 1'b1; bus.d_req = 0;
        #1;
        nvec++; if ({bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready} !== 4'b0) begin nerr++;
          $display("FAIL async_reset_strobes: got %b expected 0000", {bus.mem_en, bus.mem_we, bus.if_ready, bus.d_ready}); end
        nvec++; if ({bus.mem_addr, bus.if_rdata, bus.d_rdata} !== 96'h0) begin nerr++;
          $display("FAIL async_reset_data: got %h expected 0", {bus.mem_addr, bus.if_rdata, bus.d_rdata}); end
      end
      if (c == 3) reset = 1'b0;
      if (c == 9) begin bus.d_req = 1; bus.d_addr = 32'h100; end
      if (c == 14) bus.d_req = 0;
      @(negedge clk);
      if (c >= 3) begin
        nvec++; if (bus.d_ready !== (c == 13) || bus.mem_en !== (c == 10)) begin nerr++;
          $display("FAIL async_after_reset c%0d: got rdy %b en %b expected %b %b", c, bus.d_ready, bus.mem_en, c == 13, c == 10); end
      end
      if (c == 13) begin
        nvec++; if (bus.d_rdata !== 32'h11110100) begin nerr++;
          $display("FAIL async_next_load: got %h expected 11110100", bus.d_rdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_back_to_back();
    test_store();
    test_fairness();
    test_flush();
    test_async_reset();
    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares the single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (lw/sw) of the pipelined SAD datapath. It sequences one memory transaction at a time against a fixed-latency memory. It returns registered read data with a one-cycle ready pulse and produces stall requests that the hazard unit ORs into PCWrite/WriteIFID/controlMux. Pending fetches are aborted on branch/jump flush.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request; held until if_ready or if_flush
if_addr  in  ADDR_W  fetch address (PC); stable while if_req
if_flush  in  1  abort current/pending fetch (from branchout / taken jump)
if_rdata  out  DATA_W  fetched instruction, valid with if_ready
if_ready  out  1  one-cycle pulse, fetch complete
d_req  in  1  data request; held until d_ready
d_we  in  1  1 = store, 0 = load; stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid with d_ready
d_ready  out  1  one-cycle pulse, data access complete
mem_en  out  1  memory access strobe, high exactly one cycle per transaction
mem_we  out  1  memory write enable, only with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en cycle
stall_if  out  1  if_req & ~if_ready & ~if_flush (combinational)
stall_mem  out  1  d_req & ~d_ready (combinational)

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Counter cnt, width 4.
- Reset (async): state IDLE; cnt 0; last_d 0; abort 0; all registered outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, if_ready, d_ready, if_rdata, d_rdata). Reset mid-transaction discards the in-flight memory response, and no ready pulse follows.
- IDLE: evaluated every cycle, including the DONE-to-IDLE cycle.
  - Only d_req: grant D.
  - Only if_req & ~if_flush: grant I.
  - Both: grant D unless last_d=1, in which case grant I. This alternation prevents fetch starvation.
  - Grant: latch owner, addr, we, and wdata (D only); go to ISSUE; last_d <= (owner==D).
- ISSUE (one cycle): mem_en=1, mem_we=we & owner==D, mem_addr/mem_wdata from latches; cnt <= MEM_LAT-1; go to WAIT.
- WAIT: cnt decrements each cycle. When cnt==0, which is the cycle MEM_LAT after ISSUE:
  - Capture mem_rdata into the owner's rdata register (loads and fetches only).
  - Go to DONE.
  - With MEM_LAT=1, WAIT lasts exactly one cycle.
- DONE (one cycle): pulse the owner's ready, unless owner==I and abort=1. Go to IDLE.
- Latency: request first seen in cycle R (arbiter IDLE) → mem_en in R+1 → ready in R+2+MEM_LAT. Default is 4 cycles. Back-to-back grant: the next ISSUE follows DONE+1.
- Flush: if_flush in ISSUE/WAIT/DONE with owner==I sets abort. The memory access completes, but if_ready is suppressed and if_rdata is not updated. abort clears on entering IDLE. if_flush in IDLE blocks an I grant that cycle.
- Stores: d_rdata is unchanged; d_ready still pulses.
- d_ready and if_ready are never high in the same cycle. mem_en is never high outside ISSUE.
- Requester protocol violations (req dropped mid-transaction) do not corrupt state: the transaction completes and ready still pulses.

Test Plan:
1. MEM_LAT=2, if_req in cycle 0 with if_addr=0x40; memory returns 0x2002FFFF → mem_en in cycle 1 with mem_addr=0x40, mem_we=0; if_ready in cycle 4 with if_rdata=0x2002FFFF; stall_if high in cycles 0-3.
2. if_req and d_req (load, 0x100) both asserted in cycle 0, last_d=0 → D granted first and d_ready in cycle 4. I is then granted, mem_en in cycle 5 with 0x40, if_ready in cycle 8.
3. d_req held continuously (new requests after each ready) and if_req held → grant sequence D, I, D, I; no ready overlap.
4. Store d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF → single mem_en cycle with mem_we=1, mem_wdata=0xDEADBEEF; d_ready in cycle 4; d_rdata unchanged.
5. Fetch of 0x44 with if_flush pulsed in the WAIT cycle → no if_ready, if_rdata retains its old value; a new fetch of 0x80 is granted in the cycle after DONE.
6. reset asserted asynchronously mid-WAIT of a load → all outputs 0 immediately; after release, no d_ready pulse; the next request completes with normal 4-cycle latency.
